// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter: round-robin arbiter feeding one 8N1 UART transmitter.
// Rev 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DBITS   = 8,
    parameter int SB_TICK = 16
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             tick,
    input  logic             req0_valid,
    input  logic [DBITS-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DBITS-1:0] req1_data,
    output logic             req1_ready,
    output logic             tx,
    output logic             busy,
    output logic             grant_id,
    output logic             tx_done
);

    localparam int c_TW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int c_BW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(SB_TICK - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_TW-1:0]   r_tick_cnt, w_tick_cnt_nxt;
    logic [c_BW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [DBITS-1:0]  r_shift, w_shift_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic              r_grant_id, w_grant_id_nxt;
    logic              w_pick1;
    logic              w_tick_last;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant_id   <= w_grant_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_cnt_nxt   = r_tick_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_last_grant_nxt = r_last_grant;
        w_grant_id_nxt   = r_grant_id;
        req0_ready       = 1'b0;
        req1_ready       = 1'b0;
        tx               = 1'b1;
        busy             = 1'b0;
        tx_done          = 1'b0;
        w_tick_last      = tick && (r_tick_cnt == c_TICK_LAST);
        // Requester 1 wins when alone, or on a tie when 0 was served last.
        w_pick1          = req1_valid && (!req0_valid || !r_last_grant);

        case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready       = !w_pick1;
                    req1_ready       = w_pick1;
                    w_shift_nxt      = w_pick1 ? req1_data : req0_data;
                    w_grant_id_nxt   = w_pick1;
                    w_last_grant_nxt = w_pick1;
                    w_tick_cnt_nxt   = '0;
                    w_state_nxt      = S_START;
                end
            end
            S_START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (w_tick_last) begin
                    w_tick_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = S_DATA;
                end else if (tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + c_TW'(1);
                end
            end
            S_DATA: begin
                tx   = r_shift[0];
                busy = 1'b1;
                if (w_tick_last) begin
                    w_tick_cnt_nxt = '0;
                    w_shift_nxt    = {1'b0, r_shift[DBITS-1:1]};
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + c_BW'(1);
                    end
                end else if (tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + c_TW'(1);
                end
            end
            S_STOP: begin
                busy = 1'b1;
                if (w_tick_last) begin
                    tx_done        = 1'b1;
                    w_tick_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end else if (tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + c_TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs read idle while reset is held so no handshake or done leaks out.
        if (reset) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
            tx         = 1'b1;
            busy       = 1'b0;
            tx_done    = 1'b0;
        end
    end

    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single 8N1 UART transmit line between two byte requesters, for example the RLE encoder output stream and a status/echo source.
- Arbitrates round-robin and accepts one byte per frame over a valid/ready handshake.
- Serialises the byte LSB-first, timed by the 16x oversample tick from the baud rate generator (9600 baud, M=651 at 100 MHz).
- Sits between the encoder/status logic and the board TX pin.

Parameters:
- DBITS, 8, data bits per frame.
- SB_TICK, 16, sample ticks per bit period, used for the start bit, every data bit and the stop bit.

Ports:
- clk_100MHz  input  1  system clock (Basys 3, 100 MHz).
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle sample tick from baud_rate_generator.
- req0_valid  input  1  requester 0 has a byte.
- req0_data  input  DBITS  requester 0 byte.
- req0_ready  output  1  one-cycle accept pulse to requester 0.
- req1_valid  input  1  requester 1 has a byte.
- req1_data  input  DBITS  requester 1 byte.
- req1_ready  output  1  one-cycle accept pulse to requester 1.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  high while a frame is in progress.
- grant_id  output  1  requester that owns the current or most recent frame.
- tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (synchronous, active-high):
  - State is IDLE.
  - tx=1, busy=0, req0_ready=0, req1_ready=0, tx_done=0, grant_id=0.
  - The tick counter and bit counter are 0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset asserted mid-frame aborts the frame. tx=1 from the next cycle. No tx_done pulse. No second ready pulse for the aborted byte.
- IDLE:
  - tx=1, busy=0.
  - If any valid is high, grant in the same cycle:
    - Only one valid: grant that requester.
    - Both valid: grant the requester that is not last_grant.
  - In that cycle:
    - Assert the granted reqN_ready for exactly one cycle.
    - Capture reqN_data into the shift register.
    - Update grant_id and last_grant.
    - Clear the tick counter and go to START.
  - Acceptance does not wait for tick.
- Handshake:
  - The byte transfers only in a cycle where ready and valid are both high.
  - Requesters hold valid and data until they see ready.
  - Ready is never asserted outside IDLE.
  - Ready is never asserted to a requester whose valid is low.
- START:
  - tx=0, busy=1.
  - Count tick pulses. On a tick with count==SB_TICK-1: clear the count, clear the bit counter and go to DATA.
  - Because the tick phase is free-running, the start bit lasts more than SB_TICK-1 and at most SB_TICK tick periods.
- DATA:
  - tx = shift register bit 0.
  - On a tick with count==SB_TICK-1:
    - Shift right and clear the count.
    - If the bit counter is DBITS-1, go to STOP; otherwise increment the bit counter.
  - Bits go out LSB first, each exactly SB_TICK tick periods long.
- STOP:
  - tx=1.
  - On a tick with count==SB_TICK-1: pulse tx_done for one cycle, set busy=0 and return to IDLE.
  - A waiting request may be granted in the cycle after tx_done.
  - This gives a minimum of one clock of idle between frames.
- Ticks arriving in IDLE are ignored. The counter advances only on tick=1 cycles.
- Counter width is clog2(SB_TICK) bits. The bit counter width is clog2(DBITS) bits. Neither counter wraps because both are cleared at their terminal values.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1. Neither requester waits more than one frame.
- A requester dropping valid while not granted is legal and has no effect.
- Input data changes after acceptance do not affect the frame in flight.

Test Plan:
- Reset then idle: hold reset 3 cycles with tick pulsing every 4 cycles -> tx=1, busy=0, both ready=0, tx_done=0 throughout and after release.
- Single frame: req0_valid=1, req0_data=0x55, tick every 4 clocks:
  - req0_ready pulses exactly 1 cycle.
  - tx is 0 for start, then 1,0,1,0,1,0,1,0, then 1 for stop.
  - Each bit lasts 16 ticks (64 clocks); the start bit may be up to 1 tick short.
  - tx_done pulses once; grant_id=0.
- Tie and round-robin: both valid from reset, data 0xA1 / 0x3C, held until accepted, then reasserted with new bytes -> grant order 0,1,0,1. Decoded bytes 0xA1, 0x3C, etc. Each ready pulses once per frame.
- Back-to-back: req1 valid continuously with 0xFF then 0x00 -> the second ready comes 1 cycle after tx_done. Decoded 0xFF then 0x00. No glitch on tx between frames other than the stop/idle high.
- Reset mid-frame: assert reset during data bit 3 of 0x0F -> tx=1 next cycle, busy=0, no tx_done. The next request after reset is accepted and 0x0F is retransmitted correctly.
- Tick gating: hold tick=0 for 1000 cycles in the middle of START -> tx stays 0 and busy=1. The frame resumes and completes correctly when ticks restart.
